rpn_sequencer: RTL and testbench
================================

// Module: rpn_sequencer
// PURPOSE
//   Command initiator for the stack calculator (main). Holds a small RPN program
//   (op + operand per word), clears the calculator, issues each instruction as a
//   one-cycle apply, checks calc_valid after every step and reports final tail or
//   the failing program counter. Sits between the host/test harness and main.
// PARAMETERS
//   ADDR_W   4   program address width; program RAM depth = 2**ADDR_W words
//   DATA_W   8   operand / result width (must equal main data width)
// PORTS
//   clk          in   1         rising-edge clock shared with main
//   reset        in   1         synchronous, active-high
//   prog_we      in   1         program RAM write enable (ignored while busy)
//   prog_addr    in   ADDR_W    program RAM write address
//   prog_data    in   3+DATA_W  {op[2:0], operand[DATA_W-1:0]}
//   prog_len     in   ADDR_W+1  number of instructions; latched on start
//   start        in   1         1-cycle request; ignored unless IDLE
//   calc_clear   out  1         drives main reset; 1 for exactly one cycle per run
//   calc_in      out  DATA_W    operand to main
//   calc_op      out  3         op to main (0 push,1 pop,2 add,3 mul,4 sub,5 div,6 mod)
//   calc_apply   out  1         apply strobe to main
//   calc_tail    in   DATA_W    main tail
//   calc_valid   in   1         main valid
//   calc_empty   in   1         main empty
//   busy         out  1         high from CLEAR through CHECK of last instruction
//   done         out  1         1-cycle pulse at end of run (success or error)
//   error        out  1         sticky until next start/reset; run aborted
//   err_pc       out  ADDR_W    index of instruction that dropped calc_valid
//   result       out  DATA_W    calc_tail captured on successful completion
//   result_empty out  1         calc_empty captured on successful completion
// BEHAVIOUR
//   Reset: state IDLE; all outputs 0 (calc_in/op/apply, busy, done, error,
//     err_pc, result, result_empty, calc_clear); pc=0; RAM contents untouched.
//   States: IDLE -> CLEAR -> ISSUE <-> CHECK -> DONE -> IDLE; CHECK -> ERR -> IDLE.
//   IDLE: prog_we writes RAM. start=1: latch prog_len, pc=0, clear error -> CLEAR.
//   CLEAR (1 cycle): calc_clear=1, busy=1. len==0 -> DONE, else -> ISSUE.
//   ISSUE (1 cycle): calc_apply=1, calc_op/calc_in = RAM[pc]; main updates at the
//     closing edge. -> CHECK.
//   CHECK (1 cycle): calc_apply=0. calc_valid=0 -> err_pc=pc, ERR.
//     Else pc+1==len -> DONE; else pc<=pc+1, -> ISSUE.
//   Throughput: 2 cycles/instruction; run latency start->done = 2*len+3 cycles.
//   DONE: result<=calc_tail, result_empty<=calc_empty, done=1, busy=0 -> IDLE.
//     len==0: result=0, result_empty=1.
//   ERR: error=1 (sticky), done=1, result unchanged -> IDLE. No further apply.
//   calc_op/calc_in held at last issued value outside ISSUE; only apply qualifies.
//   Op 7 or any op main rejects is reported via calc_valid, not pre-checked.
//   prog_len > 2**ADDR_W: clamp to 2**ADDR_W at latch.
//   start while busy: ignored. prog_we while busy: ignored (no RAM write).
//   reset mid-run: back to IDLE next edge, calc_apply=0, calc_clear=0; main is
//     not cleared by this path (it shares or receives its own reset).
//   Operand order follows main: div/mod/sub use top (last pushed) op below.
// TESTING
//   Load {push 4, push 4, add}, len=3, start -> done at cycle 9, result=8, error=0.
//   {push 7, push 86, div} -> result=12; {push 7, push 86, mod} -> result=2.
//   Six pushes of 4 (capacity 5), len=6 -> error=1, err_pc=5, exactly 6 applies.
//   {push 0, push 86, div} -> error=1, err_pc=2; same with mod -> err_pc=2.
//   {push 4, push 4, add, pop} -> result_empty=1, error=0; len=0 -> done, result=0.
//   reset asserted in CHECK of pc=1 -> next cycle IDLE, busy=0, no done pulse;
//     start during busy and prog_we during busy -> no effect on run or RAM.

Source files
------------

// File: rtl/rpn_sequencer.sv
// rtl/rpn_sequencer.sv - RPN program sequencer driving the stack calculator
module rpn_sequencer #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  prog_we,
    input  logic [ADDR_W-1:0]     prog_addr,
    input  logic [3+DATA_W-1:0]   prog_data,
    input  logic [ADDR_W:0]       prog_len,
    input  logic                  start,
    output logic                  calc_clear,
    output logic [DATA_W-1:0]     calc_in,
    output logic [2:0]            calc_op,
    output logic                  calc_apply,
    input  logic [DATA_W-1:0]     calc_tail,
    input  logic                  calc_valid,
    input  logic                  calc_empty,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [ADDR_W-1:0]     err_pc,
    output logic [DATA_W-1:0]     result,
    output logic                  result_empty
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam int WORD_W = 3 + DATA_W;
    localparam logic [ADDR_W:0] MAX_LEN = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_ISSUE,
        S_CHECK,
        S_DONE,
        S_ERR
    } state_t;

    state_t              state;
    logic [WORD_W-1:0]   ram [DEPTH];
    logic [ADDR_W-1:0]   pc;
    logic [ADDR_W:0]     len;
    logic [ADDR_W:0]     len_clamped;
    logic [ADDR_W:0]     pc_inc;
    logic [WORD_W-1:0]   word_first;
    logic [WORD_W-1:0]   word_next;

    // Clamp the requested length to the RAM depth and fetch the words the FSM may issue next
    always_comb begin
        len_clamped = (prog_len > MAX_LEN) ? MAX_LEN : prog_len;
        pc_inc      = {1'b0, pc} + 1'b1;
        word_first  = ram[pc];
        word_next   = ram[pc_inc[ADDR_W-1:0]];
    end

    // Program RAM: host writes accepted only while idle; reset leaves contents alone
    always_ff @(posedge clk) begin
        if (prog_we && state == S_IDLE) begin
            ram[prog_addr] <= prog_data;
        end
    end

    // Run sequencer: clear main, alternate issue/check per instruction, report result or failing pc
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            pc           <= '0;
            len          <= '0;
            calc_clear   <= 1'b0;
            calc_in      <= '0;
            calc_op      <= '0;
            calc_apply   <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            error        <= 1'b0;
            err_pc       <= '0;
            result       <= '0;
            result_empty <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        len        <= len_clamped;
                        pc         <= '0;
                        error      <= 1'b0;
                        calc_clear <= 1'b1;
                        busy       <= 1'b1;
                        state      <= S_CLEAR;
                    end
                end
                S_CLEAR: begin
                    calc_clear <= 1'b0;
                    if (len == '0) begin
                        busy  <= 1'b0;
                        state <= S_DONE;
                    end else begin
                        calc_apply <= 1'b1;
                        calc_op    <= word_first[WORD_W-1 -: 3];
                        calc_in    <= word_first[DATA_W-1:0];
                        state      <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    // main samples the apply on the edge closing this state
                    calc_apply <= 1'b0;
                    state      <= S_CHECK;
                end
                S_CHECK: begin
                    if (!calc_valid) begin
                        err_pc <= pc;
                        busy   <= 1'b0;
                        state  <= S_ERR;
                    end else if (pc_inc == len) begin
                        busy  <= 1'b0;
                        state <= S_DONE;
                    end else begin
                        pc         <= pc_inc[ADDR_W-1:0];
                        calc_apply <= 1'b1;
                        calc_op    <= word_next[WORD_W-1 -: 3];
                        calc_in    <= word_next[DATA_W-1:0];
                        state      <= S_ISSUE;
                    end
                end
                S_DONE: begin
                    // an empty program never touches main, so report the cleared state directly
                    if (len == '0) begin
                        result       <= '0;
                        result_empty <= 1'b1;
                    end else begin
                        result       <= calc_tail;
                        result_empty <= calc_empty;
                    end
                    done  <= 1'b1;
                    state <= S_IDLE;
                end
                S_ERR: begin
                    error <= 1'b1;
                    done  <= 1'b1;
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rpn_sequencer.sv
// tb/tb_rpn_sequencer.sv - scoreboard bench for rpn_sequencer with a stack calculator model
module tb_rpn_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        prog_we;
    logic [3:0]  prog_addr;
    logic [10:0] prog_data;
    logic [4:0]  prog_len;
    logic        start;
    logic        calc_clear;
    logic [7:0]  calc_in;
    logic [2:0]  calc_op;
    logic        calc_apply;
    logic [7:0]  calc_tail;
    logic        calc_valid;
    logic        calc_empty;
    logic        busy;
    logic        done;
    logic        error;
    logic [3:0]  err_pc;
    logic [7:0]  result;
    logic        result_empty;

    int nvec = 0;
    int nerr = 0;

    typedef struct {
        logic [7:0] res;
        logic       res_empty;
        logic       err;
        logic [3:0] epc;
        int         lat;
        int         applies;
        bit         chk_res;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] last_res = 8'd0;

    always #5 clk = ~clk;

    rpn_sequencer #(.ADDR_W(4), .DATA_W(8)) dut (
        .clk(clk), .reset(reset),
        .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
        .prog_len(prog_len), .start(start),
        .calc_clear(calc_clear), .calc_in(calc_in), .calc_op(calc_op),
        .calc_apply(calc_apply), .calc_tail(calc_tail), .calc_valid(calc_valid),
        .calc_empty(calc_empty), .busy(busy), .done(done), .error(error),
        .err_pc(err_pc), .result(result), .result_empty(result_empty)
    );

    // stack calculator model: capacity 5, result = top op below, validity sticky until clear
    logic [7:0] stk [5];
    logic [2:0] cnt;
    logic       mvalid;
    logic [7:0] ma, mb, mr;

    assign calc_valid = mvalid;
    assign calc_empty = (cnt == 3'd0);
    assign calc_tail  = (cnt == 3'd0) ? 8'd0 : stk[cnt - 3'd1];

    always @(posedge clk) begin
        if (reset || calc_clear) begin
            cnt    <= 3'd0;
            mvalid <= 1'b1;
        end else if (calc_apply && mvalid) begin
            case (calc_op)
                3'd0: if (cnt == 3'd5) mvalid <= 1'b0;
                      else begin stk[cnt] <= calc_in; cnt <= cnt + 3'd1; end
                3'd1: if (cnt == 3'd0) mvalid <= 1'b0;
                      else cnt <= cnt - 3'd1;
                3'd2, 3'd3, 3'd4, 3'd5, 3'd6: begin
                    if (cnt < 3'd2) mvalid <= 1'b0;
                    else begin
                        ma = stk[cnt - 3'd1];
                        mb = stk[cnt - 3'd2];
                        if ((calc_op == 3'd5 || calc_op == 3'd6) && mb == 8'd0) mvalid <= 1'b0;
                        else begin
                            case (calc_op)
                                3'd2: mr = ma + mb;
                                3'd3: mr = ma * mb;
                                3'd4: mr = ma - mb;
                                3'd5: mr = ma / mb;
                                default: mr = ma % mb;
                            endcase
                            stk[cnt - 3'd2] <= mr;
                            cnt <= cnt - 3'd1;
                        end
                    end
                end
                default: mvalid <= 1'b0;
            endcase
        end
    end

    function automatic logic [10:0] mk(input logic [2:0] op, input logic [7:0] val);
        return {op, val};
    endfunction

    function automatic exp_t mkexp(input logic [7:0] res, input logic res_empty, input logic err,
                                   input logic [3:0] epc, input int lat, input int applies,
                                   input bit chk_res);
        exp_t e;
        e.res = res; e.res_empty = res_empty; e.err = err; e.epc = epc;
        e.lat = lat; e.applies = applies; e.chk_res = chk_res;
        return e;
    endfunction

    task automatic wr(input logic [3:0] addr, input logic [10:0] w);
        prog_we = 1'b1; prog_addr = addr; prog_data = w;
        @(posedge clk); #1;
        prog_we = 1'b0;
    endtask

    task automatic load_add_prog();
        wr(4'd0, mk(3'd0, 8'd4));
        wr(4'd1, mk(3'd0, 8'd4));
        wr(4'd2, mk(3'd2, 8'd0));
    endtask

    // start a run, optionally poke start/prog_we at cycle inj while busy, then score the outcome
    task automatic run_prog(input logic [4:0] len, input exp_t e, input int inj);
        int   cyc, napp, nclr;
        bit   seen;
        exp_t g;
        if (e.err) begin e.res = last_res; e.chk_res = 1'b1; end
        sb.push_back(e);
        start = 1'b1; prog_len = len;
        cyc = 0; napp = 0; nclr = 0; seen = 1'b0;
        while (cyc < 100 && !seen) begin
            @(posedge clk); #1;
            cyc++;
            start = 1'b0; prog_we = 1'b0;
            if (calc_apply) napp++;
            if (calc_clear) nclr++;
            if (done) seen = 1'b1;
            else if (cyc == inj) begin
                start = 1'b1; prog_len = 5'd1;
                prog_we = 1'b1; prog_addr = 4'd2; prog_data = mk(3'd0, 8'd99);
            end
        end
        g = sb.pop_front();
        nvec++;
        if (!seen) begin nerr++; $display("FAIL done_timeout: got no done, want done within 100 cycles"); end
        nvec++;
        if (cyc !== g.lat) begin nerr++; $display("FAIL latency: got %0d, want %0d", cyc, g.lat); end
        nvec++;
        if (error !== g.err) begin nerr++; $display("FAIL error: got %b, want %b", error, g.err); end
        if (g.err) begin
            nvec++;
            if (err_pc !== g.epc) begin nerr++; $display("FAIL err_pc: got %0d, want %0d", err_pc, g.epc); end
        end else begin
            nvec++;
            if (result_empty !== g.res_empty) begin nerr++; $display("FAIL result_empty: got %b, want %b", result_empty, g.res_empty); end
        end
        if (g.chk_res) begin
            nvec++;
            if (result !== g.res) begin nerr++; $display("FAIL result: got %0d, want %0d", result, g.res); end
        end
        nvec++;
        if (napp !== g.applies) begin nerr++; $display("FAIL apply_count: got %0d, want %0d", napp, g.applies); end
        nvec++;
        if (nclr !== 1) begin nerr++; $display("FAIL clear_count: got %0d, want 1", nclr); end
        nvec++;
        if (busy !== 1'b0) begin nerr++; $display("FAIL busy_at_done: got %b, want 0", busy); end
        @(posedge clk); #1;
        nvec++;
        if (done !== 1'b0) begin nerr++; $display("FAIL done_pulse_width: got %b, want 0", done); end
        if (!g.err) last_res = g.chk_res ? g.res : result;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_data = '0; prog_len = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        nvec++;
        if ({busy, done, error, calc_apply, calc_clear, result_empty} !== 6'b0) begin
            nerr++; $display("FAIL reset_flags: got %b, want 000000", {busy, done, error, calc_apply, calc_clear, result_empty});
        end
        nvec++;
        if ({calc_op, calc_in, err_pc, result} !== 23'd0) begin
            nerr++; $display("FAIL reset_values: got %h, want 0", {calc_op, calc_in, err_pc, result});
        end
    endtask

    task automatic test_add();
        load_add_prog();
        run_prog(5'd3, mkexp(8'd8, 1'b0, 1'b0, 4'd0, 9, 3, 1'b1), 0);
    endtask

    task automatic test_div_mod();
        wr(4'd0, mk(3'd0, 8'd7));
        wr(4'd1, mk(3'd0, 8'd86));
        wr(4'd2, mk(3'd5, 8'd0));
        run_prog(5'd3, mkexp(8'd12, 1'b0, 1'b0, 4'd0, 9, 3, 1'b1), 0);
        wr(4'd2, mk(3'd6, 8'd0));
        run_prog(5'd3, mkexp(8'd2, 1'b0, 1'b0, 4'd0, 9, 3, 1'b1), 0);
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 6; i++) wr(4'(i), mk(3'd0, 8'd4));
        run_prog(5'd6, mkexp(8'd0, 1'b0, 1'b1, 4'd5, 15, 6, 1'b1), 0);
    endtask

    task automatic test_div_zero();
        wr(4'd0, mk(3'd0, 8'd0));
        wr(4'd1, mk(3'd0, 8'd86));
        wr(4'd2, mk(3'd5, 8'd0));
        run_prog(5'd3, mkexp(8'd0, 1'b0, 1'b1, 4'd2, 9, 3, 1'b1), 0);
        wr(4'd2, mk(3'd6, 8'd0));
        run_prog(5'd3, mkexp(8'd0, 1'b0, 1'b1, 4'd2, 9, 3, 1'b1), 0);
    endtask

    task automatic test_pop_empty();
        load_add_prog();
        wr(4'd3, mk(3'd1, 8'd0));
        run_prog(5'd4, mkexp(8'd0, 1'b1, 1'b0, 4'd0, 11, 4, 1'b0), 0);
        run_prog(5'd0, mkexp(8'd0, 1'b1, 1'b0, 4'd0, 3, 0, 1'b1), 0);
    endtask

    task automatic test_clamp();
        wr(4'd0, mk(3'd0, 8'd1));
        for (int i = 1; i < 15; i++) wr(4'(i), (i % 2 == 1) ? mk(3'd0, 8'd1) : mk(3'd2, 8'd0));
        wr(4'd15, mk(3'd0, 8'd1));
        run_prog(5'd20, mkexp(8'd1, 1'b0, 1'b0, 4'd0, 35, 16, 1'b1), 0);
    endtask

    task automatic test_busy_ignore();
        load_add_prog();
        run_prog(5'd3, mkexp(8'd8, 1'b0, 1'b0, 4'd0, 9, 3, 1'b1), 3);
        run_prog(5'd3, mkexp(8'd8, 1'b0, 1'b0, 4'd0, 9, 3, 1'b1), 0);
    endtask

    task automatic test_reset_midrun();
        int ndone;
        wr(4'd2, mk(3'd3, 8'd0));
        start = 1'b1; prog_len = 5'd3;
        for (int c = 1; c <= 5; c++) begin
            @(posedge clk); #1;
            start = 1'b0;
        end
        nvec++;
        if (busy !== 1'b1) begin nerr++; $display("FAIL busy_midrun: got %b, want 1", busy); end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        nvec++;
        if ({busy, calc_apply, calc_clear, done} !== 4'b0) begin
            nerr++; $display("FAIL reset_midrun_flags: got %b, want 0000", {busy, calc_apply, calc_clear, done});
        end
        ndone = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (done || calc_apply) ndone++;
        end
        nvec++;
        if (ndone !== 0) begin nerr++; $display("FAIL activity_after_reset: got %0d, want 0", ndone); end
        last_res = 8'd0;
        run_prog(5'd3, mkexp(8'd16, 1'b0, 1'b0, 4'd0, 9, 3, 1'b1), 0);
    endtask

    initial begin
        test_reset();
        test_add();
        test_div_mod();
        test_overflow();
        test_div_zero();
        test_pop_empty();
        test_clamp();
        test_busy_ignore();
        test_reset_midrun();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
